// File: rtl/cordic_dds_pipe.sv
// cordic_dds_pipe: pipelined CORDIC DDS with simultaneous sin/cos outputs.
// Phase accumulator with shadowed frequency/offset registers that take effect
// on accumulator wrap (phase continuous), quadrant fold, STAGES micro-rotations
// and a saturating output stage. One sample per enabled cycle, latency STAGES+2.
// Optional: define PHASE_DITHER_EN to add LFSR phase dither before truncation.

// One CORDIC micro-rotation (rotation mode), registered.
module cordic_dds_stage #(
   parameter int XY_W  = 18,
   parameter int Z_W   = 17,
   parameter int SHIFT = 0,
   parameter int ATAN  = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [XY_W-1:0] x,
   input  logic signed [XY_W-1:0] y,
   input  logic signed [Z_W-1:0]  z,
   output logic signed [XY_W-1:0] rx,
   output logic signed [XY_W-1:0] ry,
   output logic signed [Z_W-1:0]  rz
);
   logic signed [XY_W-1:0] xs, ys;
   logic signed [Z_W-1:0]  at;

   assign xs = x >>> SHIFT;
   assign ys = y >>> SHIFT;
   assign at = Z_W'(ATAN);

   // rotate toward z = 0: positive z rotates counter-clockwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx <= '0;
         ry <= '0;
         rz <= '0;
      end else if (!z[Z_W-1]) begin
         rx <= x - ys;
         ry <= y + xs;
         rz <= z - at;
      end else begin
         rx <= x + ys;
         ry <= y - xs;
         rz <= z + at;
      end
   end
endmodule

module cordic_dds_pipe #(
   parameter int ACC_W   = 24,
   parameter int PHASE_W = 16,
   parameter int AMP_W   = 16,
   parameter int STAGES  = 14
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     fcw_wen,
   input  logic [ACC_W-1:0]         fcw_in,
   input  logic [PHASE_W-1:0]       offset_in,
   input  logic                     phase_sync,
   output logic                     update_pend,
   output logic                     out_valid,
   output logic signed [AMP_W-1:0]  sin_out,
   output logic signed [AMP_W-1:0]  cos_out
);
   localparam int XY_W    = AMP_W + 2;
   localparam int Z_W     = PHASE_W + 1;
   localparam int AMP_MAX = 2**(AMP_W-1) - 1;
   localparam int Z_BIAS  = 2**(PHASE_W-3);
   // 1/K gain compensation combined with the fixed +45 degree pre-rotation
   localparam int X0      = int'(0.6072529 * real'(AMP_MAX) * 0.70710678118654752);
   localparam logic signed [XY_W-1:0]  LIM  = XY_W'(AMP_MAX);
   localparam logic signed [AMP_W-1:0] OMAX = AMP_W'(AMP_MAX);
   localparam logic signed [AMP_W-1:0] OMIN = -OMAX;

   // atan(2^-i) with 2*pi = 2^32
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:  return 32'h2000_0000;  1:  return 32'h12E4_051E;
         2:  return 32'h09FB_385B;  3:  return 32'h0511_11D4;
         4:  return 32'h028B_0D43;  5:  return 32'h0145_D7E1;
         6:  return 32'h00A2_F61E;  7:  return 32'h0051_7C55;
         8:  return 32'h0028_BE53;  9:  return 32'h0014_5F2F;
         10: return 32'h000A_2F98;  11: return 32'h0005_17CC;
         12: return 32'h0002_8BE6;  13: return 32'h0001_45F3;
         14: return 32'h0000_A2FA;  15: return 32'h0000_517D;
         16: return 32'h0000_28BE;  17: return 32'h0000_145F;
         18: return 32'h0000_0A30;  19: return 32'h0000_0518;
         20: return 32'h0000_028C;  21: return 32'h0000_0146;
         22: return 32'h0000_00A3;  23: return 32'h0000_0051;
         24: return 32'h0000_0029;  25: return 32'h0000_0014;
         26: return 32'h0000_000A;  27: return 32'h0000_0005;
         28: return 32'h0000_0003;  29: return 32'h0000_0001;
         30: return 32'h0000_0001;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // table entry rounded to PHASE_W resolution
   function automatic int atan_q(input int i);
      logic [32:0] t;
      t = {1'b0, atan32(i)} + (33'd1 << (31 - PHASE_W));
      return int'(t >> (32 - PHASE_W));
   endfunction

   function automatic logic signed [AMP_W-1:0] sat(input logic signed [XY_W-1:0] v);
      if (v > LIM)       return OMAX;
      else if (v < -LIM) return OMIN;
      else               return v[AMP_W-1:0];
   endfunction

   // ---------------- phase generation ----------------
   logic [ACC_W-1:0]   acc, acc_sum, acc_src, fcw_act, fcw_sh, fcw_new;
   logic [PHASE_W-1:0] off_act, off_sh, off_new, phase, acc_ph;
   logic               carry, wrap;

   assign {carry, acc_sum} = {1'b0, acc} + {1'b0, fcw_act};
   assign wrap    = en & carry;
   assign fcw_new = fcw_wen ? fcw_in    : fcw_sh;
   assign off_new = fcw_wen ? offset_in : off_sh;

`ifdef PHASE_DITHER_EN
   localparam int DW = (ACC_W - PHASE_W > 15) ? 15 : ACC_W - PHASE_W;
   localparam logic [14:0] DMASK = 15'h7FFF >> (15 - DW);
   logic [14:0] lfsr;

   // x^15 + x^14 + 1 dither source, restarted by sync
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           lfsr <= 15'd1;
      else if (phase_sync) lfsr <= 15'd1;
      else if (en)         lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
   end

   assign acc_src = acc + ACC_W'(lfsr & DMASK);
`else
   assign acc_src = acc;
`endif

   assign acc_ph = PHASE_W'(acc_src >> (ACC_W - PHASE_W));
   // sync restarts at phase 0 with the newly selected offset
   assign phase  = phase_sync ? off_new : acc_ph + off_act;

   // accumulator plus active/shadow tuning words; shadow goes live on wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc         <= '0;
         fcw_act     <= '0;
         off_act     <= '0;
         fcw_sh      <= '0;
         off_sh      <= '0;
         update_pend <= 1'b0;
      end else if (phase_sync) begin
         acc         <= '0;
         fcw_act     <= fcw_new;
         off_act     <= off_new;
         fcw_sh      <= fcw_new;
         off_sh      <= off_new;
         update_pend <= 1'b0;
      end else begin
         if (en) acc <= acc_sum;
         if (fcw_wen) begin
            fcw_sh <= fcw_in;
            off_sh <= offset_in;
         end
         // fcw_new already bypasses a same-cycle write
         if (wrap) begin
            fcw_act     <= fcw_new;
            off_act     <= off_new;
            update_pend <= 1'b0;
         end else if (fcw_wen) begin
            update_pend <= 1'b1;
         end
      end
   end

   // ---------------- CORDIC pipeline ----------------
   logic signed [XY_W-1:0] x_p [0:STAGES];
   logic signed [XY_W-1:0] y_p [0:STAGES];
   logic signed [Z_W-1:0]  z_p [0:STAGES];
   logic [1:0]             q_pipe [0:STAGES];
   logic signed [XY_W-1:0] x0_r, y0_r;
   logic signed [Z_W-1:0]  z0_r;
   logic [STAGES+1:0]      vld_pipe;

   // quadrant fold: residual angle biased by -pi/4 into [-pi/4, pi/4)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x0_r <= '0;
         y0_r <= '0;
         z0_r <= '0;
      end else begin
         x0_r <= XY_W'(X0);
         y0_r <= XY_W'(X0);
         z0_r <= Z_W'({2'b00, phase[PHASE_W-3:0]}) - Z_W'(Z_BIAS);
      end
   end

   // quadrant travels alongside the rotation stages
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s <= STAGES; s++) q_pipe[s] <= '0;
      end else begin
         q_pipe[0] <= phase[PHASE_W-1 -: 2];
         for (int s = 1; s <= STAGES; s++) q_pipe[s] <= q_pipe[s-1];
      end
   end

   assign x_p[0] = x0_r;
   assign y_p[0] = y0_r;
   assign z_p[0] = z0_r;

   for (genvar s = 1; s <= STAGES; s++) begin : g_stage
      cordic_dds_stage #(
         .XY_W (XY_W),
         .Z_W  (Z_W),
         .SHIFT(s - 1),
         .ATAN (atan_q(s - 1))
      ) u_stage (
         .clk(clk),
         .rst(reset),
         .x  (x_p[s-1]),
         .y  (y_p[s-1]),
         .z  (z_p[s-1]),
         .rx (x_p[s]),
         .ry (y_p[s]),
         .rz (z_p[s])
      );
   end

   // ---------------- output mapping ----------------
   logic signed [XY_W-1:0] xf, yf, sin_raw, cos_raw;
   assign xf = x_p[STAGES];
   assign yf = y_p[STAGES];

   // unfold quadrant: rotate the first-quadrant result by q * 90 degrees
   always_comb begin
      sin_raw = yf;
      cos_raw = xf;
      case (q_pipe[STAGES])
         2'd0: begin sin_raw =  yf; cos_raw =  xf; end
         2'd1: begin sin_raw =  xf; cos_raw = -yf; end
         2'd2: begin sin_raw = -yf; cos_raw = -xf; end
         default: begin sin_raw = -xf; cos_raw = yf; end
      endcase
   end

   // valid shift register and saturating output register (holds on bubbles)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         sin_out  <= '0;
         cos_out  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES:0], en};
         if (vld_pipe[STAGES]) begin
            sin_out <= sat(sin_raw);
            cos_out <= sat(cos_raw);
         end
      end
   end

   assign out_valid = vld_pipe[STAGES+1];
endmodule

// File: tb/tb_cordic_dds_pipe.sv
// Directed self-checking bench for cordic_dds_pipe (default parameters).
module tb_cordic_dds_pipe;
   localparam int ACC_W = 24, PHASE_W = 16, AMP_W = 16;
   localparam int LAT = 16;   // STAGES + 2
   localparam int TOL = 16;   // CORDIC residual angle + phase quantisation

   logic clk = 1'b0, reset = 1'b1, en = 1'b0, fcw_wen = 1'b0, phase_sync = 1'b0;
   logic [ACC_W-1:0]   fcw_in = '0;
   logic [PHASE_W-1:0] offset_in = '0;
   logic update_pend, out_valid;
   logic signed [AMP_W-1:0] sin_out, cos_out;

   int checks = 0, errors = 0, cyc = 0;
   int vq[$], sq[$], cq[$];
   // round(32767*sin(2*pi*k/16))
   int sin16[16] = '{0, 12539, 23170, 30273, 32767, 30273, 23170, 12539,
                     0, -12539, -23170, -30273, -32767, -30273, -23170, -12539};

   cordic_dds_pipe dut (
      .clk(clk), .reset(reset), .en(en), .fcw_wen(fcw_wen), .fcw_in(fcw_in),
      .offset_in(offset_in), .phase_sync(phase_sync), .update_pend(update_pend),
      .out_valid(out_valid), .sin_out(sin_out), .cos_out(cos_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // capture every valid sample with its cycle stamp
   always @(negedge clk) begin
      if (out_valid) begin
         vq.push_back(cyc);
         sq.push_back(int'(sin_out));
         cq.push_back(int'(cos_out));
      end
   end

   task automatic chk(input string tag, input int got, input int exp, input int tol);
      int d;
      d = got - exp;
      if (d < 0) d = -d;
      checks++;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      vq.delete(); sq.delete(); cq.delete();
   endtask

   // sync with en=0 to a known fcw/offset, accumulator at 0
   task automatic sync_idle(input logic [ACC_W-1:0] f, input logic [PHASE_W-1:0] o);
      fcw_wen = 1; fcw_in = f; offset_in = o; phase_sync = 1; en = 0;
      tick();
      fcw_wen = 0; phase_sync = 0;
   endtask

   // single sample launched by sync+en at fcw=0
   task automatic launch_sync(input string name, input logic [PHASE_W-1:0] off,
                              input int es, input int ec);
      int c0, n;
      clear_q();
      fcw_wen = 1; fcw_in = '0; offset_in = off; phase_sync = 1; en = 1;
      c0 = cyc;
      tick();
      fcw_wen = 0; phase_sync = 0; en = 0;
      n = 0;
      while (vq.size() == 0 && n < 40) begin tick(); n++; end
      repeat (4) tick();
      chk({name, "_count"}, vq.size(), 1, 0);
      if (vq.size() > 0) begin
         chk({name, "_lat"}, vq[0] - c0, LAT, 0);
         chk({name, "_sin"}, sq[0], es, TOL);
         chk({name, "_cos"}, cq[0], ec, TOL);
         chk({name, "_nomin"}, int'(sq[0] == -32768 || cq[0] == -32768), 0, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int nbad, nmin;
      int lq[$];

      // reset state
      repeat (3) tick();
      chk("rst_sin", sin_out, 0, 0);
      chk("rst_cos", cos_out, 0, 0);
      chk("rst_valid", out_valid, 0, 0);
      chk("rst_pend", update_pend, 0, 0);
      reset = 0;
      clear_q();
      repeat (20) tick();
      chk("idle_valid", vq.size(), 0, 0);
      chk("idle_sin", sin_out, 0, 0);
      chk("idle_cos", cos_out, 0, 0);
      chk("idle_pend", update_pend, 0, 0);

      // single points, all quadrants
      launch_sync("ph0000", 16'h0000, 0, 32767);
      launch_sync("ph4000", 16'h4000, 32767, 0);
      launch_sync("ph8000", 16'h8000, 0, -32767);
      launch_sync("phC000", 16'hC000, -32767, 0);
      launch_sync("ph1000", 16'h1000, 12539, 30273);
      launch_sync("ph2000", 16'h2000, 23170, 23170);

      // period-16 tone
      clear_q();
      sync_idle(24'h100000, 16'h0000);
      en = 1;
      repeat (48) tick();
      en = 0;
      repeat (24) tick();
      chk("per_count", vq.size(), 48, 0);
      if (vq.size() == 48) begin
         for (int k = 0; k < 16; k++) begin
            chk($sformatf("per_sin%0d", k), sq[k], sin16[k], TOL);
            chk($sformatf("per_cos%0d", k), cq[k], sin16[(k + 4) % 16], TOL);
         end
         nbad = 0; nmin = 0;
         for (int k = 16; k < 48; k++)
            if (sq[k] != sq[k-16] || cq[k] != cq[k-16]) nbad++;
         for (int k = 0; k < 48; k++)
            if (sq[k] == -32768 || cq[k] == -32768) nmin++;
         chk("per_repeat", nbad, 0, 0);
         chk("per_nomin", nmin, 0, 0);
      end

      // shadowed fcw write mid-period goes live at the wrap
      clear_q();
      sync_idle(24'h100000, 16'h0000);
      for (int n = 0; n < 24; n++) begin
         en = 1; fcw_wen = (n == 5); fcw_in = 24'h200000; offset_in = 16'h0000;
         tick();
         if (n == 5)  chk("upd_pend_set", update_pend, 1, 0);
         if (n == 14) chk("upd_pend_hold", update_pend, 1, 0);
         if (n == 15) chk("upd_pend_clr", update_pend, 0, 0);
      end
      en = 0; fcw_wen = 0;
      repeat (24) tick();
      chk("upd_count", vq.size(), 24, 0);
      if (vq.size() == 24) begin
         chk("upd_s14", sq[14], -23170, TOL);
         chk("upd_s15", sq[15], -12539, TOL);
         chk("upd_s16", sq[16], 0, TOL);
         chk("upd_s17", sq[17], 23170, TOL);
         chk("upd_s18", sq[18], 32767, TOL);
         chk("upd_s19", sq[19], 23170, TOL);
         chk("upd_s20", sq[20], 0, TOL);
      end

      // write on the wrap cycle bypasses the shadow (new offset too)
      clear_q();
      sync_idle(24'h100000, 16'h0000);
      for (int n = 0; n < 20; n++) begin
         en = 1; fcw_wen = (n == 15); fcw_in = 24'h200000; offset_in = 16'h1000;
         tick();
         if (n == 15) chk("byp_pend_wrap", update_pend, 0, 0);
         if (n == 16) chk("byp_pend_after", update_pend, 0, 0);
      end
      en = 0; fcw_wen = 0;
      repeat (24) tick();
      chk("byp_count", vq.size(), 20, 0);
      if (vq.size() == 20) begin
         chk("byp_s15", sq[15], -12539, TOL);
         chk("byp_s16", sq[16], 12539, TOL);
         chk("byp_s17", sq[17], 30273, TOL);
         chk("byp_s18", sq[18], 30273, TOL);
      end

      // alternating en: valid pattern is en delayed by LAT
      clear_q();
      sync_idle(24'h100000, 16'h0000);
      lq.delete();
      for (int n = 0; n < 20; n++) begin
         en = (n % 2 == 0);
         if (en) lq.push_back(cyc);
         tick();
      end
      en = 0;
      repeat (24) tick();
      chk("tog_count", vq.size(), 10, 0);
      nbad = 0;
      for (int i = 0; i < vq.size() && i < lq.size(); i++)
         if (vq[i] != lq[i] + LAT) nbad++;
      chk("tog_timing", nbad, 0, 0);

      // asynchronous reset mid-stream
      clear_q();
      sync_idle(24'h100000, 16'h1000);
      en = 1;
      repeat (20) tick();
      fcw_wen = 1; fcw_in = 24'h300000;
      tick();
      fcw_wen = 0;
      chk("pre_rst_valid", out_valid, 1, 0);
      chk("pre_rst_pend", update_pend, 1, 0);
      chk("pre_rst_nz", int'(sin_out != 0 || cos_out != 0), 1, 0);
      #2 reset = 1;
      #1;
      chk("arst_sin", sin_out, 0, 0);
      chk("arst_cos", cos_out, 0, 0);
      chk("arst_valid", out_valid, 0, 0);
      chk("arst_pend", update_pend, 0, 0);
      en = 0;
      clear_q();
      repeat (3) tick();
      reset = 0;
      repeat (24) tick();
      chk("post_rst_valid", vq.size(), 0, 0);

      launch_sync("ph6000", 16'h6000, 23170, -23170);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
